rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter RESET_HOLD, default 16: system-reset hold length in clk_24 cycles after reset or download end.
REQ-002 Parameter PGROM_SIZE 32768, CHROM_SIZE 2048, PALROM_SIZE 32, SPROM_SIZE 4096: byte limits for indices 0, 1, 2, 3.
REQ-003 clk_24  in  1  sole clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high for the whole duration of a download.
REQ-006 ioctl_index  in  8  target region, valid while ioctl_download high.
REQ-007 ioctl_wr  in  1  single-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address within the region.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 dn_addr  out  17  registered write address to the system.
REQ-011 dn_data  out  8  registered write data.
REQ-012 dn_wr  out  1  registered write strobe.
REQ-013 dn_index  out  8  region index latched at download start.
REQ-014 sys_reset  out  1  active-high hold-in-reset for the system.
REQ-015 error  out  1  sticky: out-of-range write seen in the current/last download.
REQ-016 byte_count  out  17  accepted bytes in the current/last download.
REQ-017 checksum  out  8  mod-256 sum of accepted bytes.

Function
REQ-018 FSM states HOLD, IDLE, LOAD; sys_reset SHALL be 1 in HOLD and LOAD, 0 in IDLE.
REQ-019 HOLD: down-counter decrements each cycle; IDLE entered on the cycle after it reaches 0; total HOLD duration exactly RESET_HOLD cycles.
REQ-020 Rising edge of ioctl_download (registered previous value) from any state SHALL enter LOAD, latch dn_index, and clear error, byte_count, checksum.
REQ-021 LOAD exits to HOLD (counter reloaded) on the first cycle ioctl_download is sampled low.
REQ-022 A write is accepted when ioctl_wr=1, ioctl_download=1, ioctl_index<=3, and ioctl_addr < the limit for that index.
REQ-023 Accepted write: dn_wr=1 for exactly one cycle, one cycle after ioctl_wr, with dn_addr=ioctl_addr[16:0] and dn_data=ioctl_dout; back-to-back writes every cycle are supported with no gaps or loss.
REQ-024 dn_addr and dn_data SHALL hold their last values while dn_wr=0.
REQ-025 An out-of-range write (index<=3, addr >= limit) SHALL be suppressed (no dn_wr) and set error.
REQ-026 Writes with ioctl_index>3, or with ioctl_download low, SHALL be suppressed silently; error unchanged.
REQ-027 byte_count increments per accepted write, saturating at 17'h1FFFF; checksum adds the data byte modulo 256.
REQ-028 A write on the same cycle as the download rising edge SHALL be accepted and counted after the clear.
REQ-029 A write on the final cycle before ioctl_download is sampled low SHALL be accepted.
REQ-030 dn_index, error, byte_count, checksum SHALL hold after the download until the next download start.

Reset
REQ-031 While reset_n=0: state HOLD, counter=RESET_HOLD-1, sys_reset=1, dn_wr=0, dn_addr=0, dn_data=0, dn_index=0, error=0, byte_count=0, checksum=0, previous-download register=0.
REQ-032 reset_n assertion mid-download SHALL abort immediately; after release the block SHALL run HOLD then IDLE, or enter LOAD if ioctl_download is high at release (rising edge seen from reset value 0).

Structure
REQ-033 Region index constants (0..3), region size constants, and the FSM state encoding SHALL reside in a shared package used by the system and this block.
REQ-034 No sub-module; the hold counter is inline.

Verification
REQ-035 Reset release, ioctl_download=0 -> sys_reset=1 for exactly 16 cycles, then 0; dn_wr never 1.
REQ-036 Index 0, bytes 0x11,0x22,0x33 at addr 0..2 on consecutive cycles -> three dn_wr pulses, each one cycle late, with matching addr/data; byte_count=3, checksum=0x66, error=0.
REQ-037 Index 2, addr 31 data 0xAA then addr 32 data 0x55 -> one dn_wr (addr 31); error=1; byte_count=1, checksum=0xAA.
REQ-038 Index 5, 4 writes -> no dn_wr, error=0, byte_count=0; dn_index=5.
REQ-039 Download falls -> sys_reset stays 1 for 16 more cycles; new download starting at hold cycle 8 -> LOAD, counters cleared, sys_reset continuous.
REQ-040 reset_n pulsed low mid-download at byte 100 -> outputs cleared asynchronously, no further dn_wr until reset released; download still high at release -> LOAD with byte_count restarting at 0.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM download path: region indices, region sizes and loader FSM states.
package rom_loader_pkg;

  localparam logic [7:0] RegionPgrom  = 8'd0;
  localparam logic [7:0] RegionChrom  = 8'd1;
  localparam logic [7:0] RegionPalrom = 8'd2;
  localparam logic [7:0] RegionSprom  = 8'd3;

  localparam int unsigned PgromSize  = 32768;
  localparam int unsigned ChromSize  = 2048;
  localparam int unsigned PalromSize = 32;
  localparam int unsigned SpromSize  = 4096;

  typedef logic [24:0] ioctl_addr_t;
  typedef logic [16:0] dn_addr_t;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StIdle = 2'd1,
    StLoad = 2'd2
  } ld_state_e;

endpackage

// File: rtl/rom_loader_if.sv
// Download bus: ioctl byte stream from the host side and the registered write port to the system.
interface rom_loader_if;

  logic                       ioctl_download;
  logic [7:0]                 ioctl_index;
  logic                       ioctl_wr;
  rom_loader_pkg::ioctl_addr_t ioctl_addr;
  logic [7:0]                 ioctl_dout;

  rom_loader_pkg::dn_addr_t   dn_addr;
  logic [7:0]                 dn_data;
  logic                       dn_wr;
  logic [7:0]                 dn_index;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, dn_index
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, dn_index
  );

endinterface

// File: rtl/rom_loader.sv
// ROM loader: filters and registers ioctl download bytes into per-region writes and holds the
// system in reset during and shortly after each download.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned RESET_HOLD  = 16,
  parameter int unsigned PGROM_SIZE  = PgromSize,
  parameter int unsigned CHROM_SIZE  = ChromSize,
  parameter int unsigned PALROM_SIZE = PalromSize,
  parameter int unsigned SPROM_SIZE  = SpromSize
) (
  input  logic               clk_24,
  input  logic               reset_n,
  rom_loader_if.slave        bus,
  output logic               sys_reset,
  output logic               error,
  output logic [16:0]        byte_count,
  output logic [7:0]         checksum
);

  localparam int unsigned CntW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CntW-1:0] HoldInit = CntW'(RESET_HOLD - 1);

  ld_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            download_q;
  logic            dn_wr_q, dn_wr_d;
  dn_addr_t        dn_addr_q, dn_addr_d;
  logic [7:0]      dn_data_q, dn_data_d;
  logic [7:0]      dn_index_q, dn_index_d;
  logic            error_q, error_d;
  logic [16:0]     count_q, count_d;
  logic [7:0]      sum_q, sum_d;

  ioctl_addr_t limit;
  logic        idx_ok;
  logic        wr_valid;
  logic        accept;
  logic        out_of_range;
  logic        dl_rise;

  always_comb begin
    idx_ok = 1'b1;
    limit  = '0;
    case (bus.ioctl_index)
      RegionPgrom:  limit = ioctl_addr_t'(PGROM_SIZE);
      RegionChrom:  limit = ioctl_addr_t'(CHROM_SIZE);
      RegionPalrom: limit = ioctl_addr_t'(PALROM_SIZE);
      RegionSprom:  limit = ioctl_addr_t'(SPROM_SIZE);
      default:      idx_ok = 1'b0;
    endcase
  end

  assign dl_rise      = bus.ioctl_download & ~download_q;
  assign wr_valid     = bus.ioctl_wr & bus.ioctl_download & idx_ok;
  assign accept       = wr_valid & (bus.ioctl_addr < limit);
  assign out_of_range = wr_valid & ~(bus.ioctl_addr < limit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dn_wr_d    = accept;
    dn_addr_d  = accept ? bus.ioctl_addr[16:0] : dn_addr_q;
    dn_data_d  = accept ? bus.ioctl_dout : dn_data_q;
    dn_index_d = dn_index_q;
    error_d    = error_q;
    count_d    = count_q;
    sum_d      = sum_q;

    unique case (state_q)
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StIdle: ;
      StLoad: begin
        if (!bus.ioctl_download) begin
          state_d = StHold;
          cnt_d   = HoldInit;
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = HoldInit;
      end
    endcase

    // A new download wins over any state; a write in the same cycle lands after the clear.
    if (dl_rise) begin
      state_d    = StLoad;
      dn_index_d = bus.ioctl_index;
      error_d    = 1'b0;
      count_d    = '0;
      sum_d      = '0;
    end

    if (accept) begin
      if (count_d != '1) count_d = count_d + 17'd1;
      sum_d = sum_d + bus.ioctl_dout;
    end

    if (out_of_range) error_d = 1'b1;
  end

  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHold;
      cnt_q      <= HoldInit;
      download_q <= 1'b0;
      dn_wr_q    <= 1'b0;
      dn_addr_q  <= '0;
      dn_data_q  <= '0;
      dn_index_q <= '0;
      error_q    <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      download_q <= bus.ioctl_download;
      dn_wr_q    <= dn_wr_d;
      dn_addr_q  <= dn_addr_d;
      dn_data_q  <= dn_data_d;
      dn_index_q <= dn_index_d;
      error_q    <= error_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
    end
  end

  assign bus.dn_wr    = dn_wr_q;
  assign bus.dn_addr  = dn_addr_q;
  assign bus.dn_data  = dn_data_q;
  assign bus.dn_index = dn_index_q;
  assign sys_reset    = (state_q != StIdle);
  assign error        = error_q;
  assign byte_count   = count_q;
  assign checksum     = sum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven download scenarios plus reset/hold corner cases,
// with a scoreboard checking every dn_wr pulse for address, data and one-cycle latency.
module tb_rom_loader;

  logic        clk_24 = 1'b0;
  logic        reset_n;
  logic        sys_reset;
  logic        error;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  rom_loader_if bus ();

  rom_loader dut (
    .clk_24     (clk_24),
    .reset_n    (reset_n),
    .bus        (bus),
    .sys_reset  (sys_reset),
    .error      (error),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  always #5 clk_24 = ~clk_24;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    bit          acc;
  } wvec_t;

  typedef struct {
    logic [7:0]  dl_idx;
    int          first;
    int          n;
    bit          err;
    logic [16:0] cnt;
    logic [7:0]  sum;
  } scn_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int          cyc;
  } sb_t;

  wvec_t wtab[17];
  scn_t  stab[4];
  sb_t   exp_q[$];

  int          cyc = 0;
  int          nchecks = 0;
  int          npass = 0;
  logic [16:0] last_addr = '0;
  logic [7:0]  last_data = '0;

  always @(posedge clk_24) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard consumer, sampling on the falling edge.
  always @(negedge clk_24) begin
    if (!reset_n) begin
      last_addr = '0;
      last_data = '0;
      chk("dn_wr_in_reset", {31'd0, bus.dn_wr}, 32'd0);
    end else if (bus.dn_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dn_wr", {15'd0, bus.dn_addr}, 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("dn_addr", {15'd0, bus.dn_addr}, {15'd0, e.addr});
        chk("dn_data", {24'd0, bus.dn_data}, {24'd0, e.data});
        chk("dn_wr_latency", cyc, e.cyc);
        last_addr = bus.dn_addr;
        last_data = bus.dn_data;
      end
    end else begin
      chk("dn_hold", {7'd0, bus.dn_addr, bus.dn_data}, {7'd0, last_addr, last_data});
    end
  end

  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic drive_wr(input wvec_t v);
    sb_t e;
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_index = v.idx;
    bus.ioctl_addr  = v.addr;
    bus.ioctl_dout  = v.data;
    if (v.acc) begin
      e.addr = v.addr[16:0];
      e.data = v.data;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // Counts post-edge samples with sys_reset high until it drops (bounded).
  task automatic hold_len(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!sys_reset) break;
      n++;
    end
  endtask

  task automatic check_status(input string tag, input bit err, input logic [16:0] cnt,
                              input logic [7:0] sum, input logic [7:0] idx);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, err});
    chk({tag, "_byte_count"}, {15'd0, byte_count}, {15'd0, cnt});
    chk({tag, "_checksum"}, {24'd0, checksum}, {24'd0, sum});
    chk({tag, "_dn_index"}, {24'd0, bus.dn_index}, {24'd0, idx});
  endtask

  initial begin
    int    n;
    bit    cont;
    wvec_t v;

    wtab[0]  = '{8'd0, 25'd0,          8'h11, 1'b1};
    wtab[1]  = '{8'd0, 25'd1,          8'h22, 1'b1};
    wtab[2]  = '{8'd0, 25'd2,          8'h33, 1'b1};
    wtab[3]  = '{8'd2, 25'd31,         8'hAA, 1'b1};
    wtab[4]  = '{8'd2, 25'd32,         8'h55, 1'b0};
    wtab[5]  = '{8'd5, 25'd0,          8'h01, 1'b0};
    wtab[6]  = '{8'd5, 25'd1,          8'h02, 1'b0};
    wtab[7]  = '{8'd5, 25'd2,          8'h03, 1'b0};
    wtab[8]  = '{8'd5, 25'd3,          8'h04, 1'b0};
    wtab[9]  = '{8'd0, 25'd32767,      8'h01, 1'b1};
    wtab[10] = '{8'd0, 25'd32768,      8'h02, 1'b0};
    wtab[11] = '{8'd1, 25'd2047,       8'h03, 1'b1};
    wtab[12] = '{8'd1, 25'd2048,       8'hF0, 1'b0};
    wtab[13] = '{8'd3, 25'd4095,       8'h04, 1'b1};
    wtab[14] = '{8'd3, 25'd4096,       8'hF1, 1'b0};
    wtab[15] = '{8'd0, 25'h100_0005,   8'hF2, 1'b0};
    wtab[16] = '{8'd2, 25'd0,          8'h80, 1'b1};

    stab[0] = '{8'd0, 0,  3, 1'b0, 17'd3, 8'h66};
    stab[1] = '{8'd2, 3,  2, 1'b1, 17'd1, 8'hAA};
    stab[2] = '{8'd5, 5,  4, 1'b0, 17'd0, 8'h00};
    stab[3] = '{8'd0, 9,  8, 1'b1, 17'd4, 8'h88};

    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    tick();
    tick();
    chk("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
    chk("rst_dn_wr", {31'd0, bus.dn_wr}, 32'd0);
    chk("rst_dn_addr", {15'd0, bus.dn_addr}, 32'd0);
    chk("rst_dn_data", {24'd0, bus.dn_data}, 32'd0);
    check_status("rst", 1'b0, 17'd0, 8'h00, 8'd0);

    // Release: the interval before the first edge plus the high post-edge samples make the hold.
    reset_n = 1'b1;
    hold_len(n);
    chk("reset_hold_cycles", n + 1, 16);
    chk("idle_sys_reset", {31'd0, sys_reset}, 32'd0);

    foreach (stab[s]) begin
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = stab[s].dl_idx;
      for (int w = 0; w < stab[s].n; w++) begin
        drive_wr(wtab[stab[s].first + w]);
        tick();
      end
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_download = 1'b0;
      hold_len(n);
      chk($sformatf("scn%0d_hold", s), n, 16);
      check_status($sformatf("scn%0d", s), stab[s].err, stab[s].cnt, stab[s].sum,
                   stab[s].dl_idx);
    end

    // New download arriving in the middle of the post-download hold.
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd2;
    v = '{8'd2, 25'd40, 8'h77, 1'b0};
    drive_wr(v);
    tick();
    v = '{8'd2, 25'd0, 8'h10, 1'b1};
    drive_wr(v);
    tick();
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    cont = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!sys_reset) cont = 1'b0;
    end
    check_status("pre_restart", 1'b1, 17'd1, 8'h10, 8'd2);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd1;
    tick();
    if (!sys_reset) cont = 1'b0;
    check_status("restart", 1'b0, 17'd0, 8'h00, 8'd1);
    v = '{8'd1, 25'd5, 8'h21, 1'b1};
    drive_wr(v);
    tick();
    if (!sys_reset) cont = 1'b0;
    chk("restart_sys_reset_cont", {31'd0, cont}, 32'd1);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    hold_len(n);
    chk("restart_hold", n, 16);
    check_status("restart_end", 1'b0, 17'd1, 8'h21, 8'd1);

    // Asynchronous reset in the middle of a long download.
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    for (int i = 0; i < 100; i++) begin
      v.idx  = 8'd0;
      v.addr = 25'(i);
      v.data = 8'(i) ^ 8'h3C;
      v.acc  = 1'b1;
      drive_wr(v);
      tick();
    end
    bus.ioctl_wr = 1'b0;
    tick();
    chk("pre_abort_count", {15'd0, byte_count}, 32'd100);
    @(negedge clk_24);
    #2;
    reset_n = 1'b0;
    v = '{8'd0, 25'd100, 8'hEE, 1'b0};
    drive_wr(v);
    #1;
    chk("abort_dn_addr", {15'd0, bus.dn_addr}, 32'd0);
    chk("abort_dn_data", {24'd0, bus.dn_data}, 32'd0);
    chk("abort_sys_reset", {31'd0, sys_reset}, 32'd1);
    check_status("abort", 1'b0, 17'd0, 8'h00, 8'd0);
    tick();
    tick();
    tick();
    chk("in_reset_count", {15'd0, byte_count}, 32'd0);
    reset_n = 1'b1;
    v = '{8'd0, 25'd0, 8'h5A, 1'b1};
    drive_wr(v);
    tick();
    bus.ioctl_wr = 1'b0;
    chk("rearm_sys_reset", {31'd0, sys_reset}, 32'd1);
    check_status("rearm", 1'b0, 17'd1, 8'h5A, 8'd0);
    bus.ioctl_download = 1'b0;
    hold_len(n);
    chk("rearm_hold", n, 16);

    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
